// File: rtl/adder_pkg.sv
// ============================================================================
// Module : adder_pkg
// Brief  : Shared FSM state encoding and vector-width helper for adder_vec_seq
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adder_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DRIVE   = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_FINISH  = 3'd4
    } state_t;

    // A stored vector is {a, b, cin}.
    function automatic int vec_width(input int width);
        return 2 * width + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vec_mem.sv
// ============================================================================
// Module : vec_mem
// Brief  : Vector memory, synchronous write and combinational read, no reset
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vec_mem #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/adder_vec_seq.sv
// ============================================================================
// Module : adder_vec_seq
// Brief  : Plays stored {a,b,cin} vectors into an external adder and captures
//          each {y,x} response after a fixed settle time
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_vec_seq
    import adder_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int DEPTH  = 8,
    parameter int SETTLE = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ld_en,
    input  logic [$clog2(DEPTH)-1:0]   ld_addr,
    input  logic [2*WIDTH:0]           ld_data,
    input  logic                       start,
    input  logic [$clog2(DEPTH):0]     num_vec,
    output logic [WIDTH-1:0]           a,
    output logic [WIDTH-1:0]           b,
    output logic                       cin,
    input  logic [WIDTH-1:0]           x,
    input  logic                       y,
    output logic                       res_valid,
    output logic [$clog2(DEPTH)-1:0]   res_idx,
    output logic [WIDTH:0]             res_data,
    output logic                       busy,
    output logic                       done
);

    localparam int             AW      = $clog2(DEPTH);
    localparam int             VW      = vec_width(WIDTH);
    localparam logic [AW:0]    c_depth = (AW+1)'(DEPTH);

    state_t          r_state;
    logic [AW:0]     r_idx;
    logic [AW:0]     r_len;
    logic [3:0]      r_cnt;
    logic [VW-1:0]   w_rd_data;
    logic [AW:0]     w_len;
    logic [AW:0]     w_next_idx;
    logic            w_wr_en;

    // Writes are only honoured while idle so a running sequence sees fixed data.
    assign w_wr_en    = ld_en && (r_state == S_IDLE);
    assign w_len      = (num_vec > c_depth) ? c_depth : num_vec;
    assign w_next_idx = r_idx + 1'b1;

    vec_mem #(
        .DEPTH (DEPTH),
        .WIDTH (VW)
    ) u_vec_mem (
        .clk     (clk),
        .i_we    (w_wr_en),
        .i_waddr (ld_addr),
        .i_wdata (ld_data),
        .i_raddr (r_idx[AW-1:0]),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            a         <= '0;
            b         <= '0;
            cin       <= 1'b0;
            res_valid <= 1'b0;
            res_idx   <= '0;
            res_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx   <= '0;
                        r_len   <= w_len;
                        busy    <= 1'b1;
                        r_state <= (num_vec != '0) ? S_DRIVE : S_FINISH;
                    end
                end
                S_DRIVE: begin
                    {a, b, cin} <= w_rd_data;
                    r_cnt       <= 4'(SETTLE - 1);
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_CAPTURE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_CAPTURE: begin
                    res_data  <= {y, x};
                    res_idx   <= r_idx[AW-1:0];
                    res_valid <= 1'b1;
                    // The index is one bit wider than the address so it never wraps.
                    r_idx     <= w_next_idx;
                    r_state   <= (w_next_idx < r_len) ? S_DRIVE : S_FINISH;
                end
                S_FINISH: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_adder_vec_seq.sv
// ============================================================================
// Module : tb_adder_vec_seq
// Brief  : Directed self-checking bench for adder_vec_seq with a full adder
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_vec_seq;

    logic       clk;
    logic       rst;
    logic       ld_en;
    logic [2:0] ld_addr;
    logic [2:0] ld_data;
    logic       start;
    logic       start3;
    logic [3:0] num_vec;

    logic       a, b, cin, x, y, res_valid, busy, done;
    logic [2:0] res_idx;
    logic [1:0] res_data;

    logic       a3, b3, cin3, x3, y3, res_valid3, busy3, done3;
    logic [2:0] res_idx3;
    logic [1:0] res_data3;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0] mem_m  [8];
    logic [1:0] exp22  [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    logic [1:0] res_d  [16];
    logic [2:0] res_i  [16];
    int         res_t  [16];

    // Downstream full adders
    assign {y, x}   = 2'(a)  + 2'(b)  + 2'(cin);
    assign {y3, x3} = 2'(a3) + 2'(b3) + 2'(cin3);

    adder_vec_seq #(.WIDTH(1), .DEPTH(8), .SETTLE(2)) dut (
        .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start), .num_vec(num_vec), .a(a), .b(b), .cin(cin), .x(x), .y(y),
        .res_valid(res_valid), .res_idx(res_idx), .res_data(res_data),
        .busy(busy), .done(done)
    );

    adder_vec_seq #(.WIDTH(1), .DEPTH(8), .SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start3), .num_vec(num_vec), .a(a3), .b(b3), .cin(cin3), .x(x3), .y(y3),
        .res_valid(res_valid3), .res_idx(res_idx3), .res_data(res_data3),
        .busy(busy3), .done(done3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] fa(input logic [2:0] v);
        return 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
    endfunction

    task automatic load(input logic [2:0] addr, input logic [2:0] data);
        ld_en = 1'b1; ld_addr = addr; ld_data = data;
        tick();
        ld_en = 1'b0;
    endtask

    // Starts a run on the SETTLE=2 instance and records every response.
    task automatic run_collect(input logic [3:0] nv, output int nres, output int ndone);
        nres = 0; ndone = 0;
        num_vec = nv; start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 200 && ndone == 0; n++) begin
            if (res_valid && nres < 16) begin
                res_d[nres] = res_data;
                res_i[nres] = res_idx;
                res_t[nres] = n;
                nres++;
            end
            if (done) ndone++;
            tick();
        end
        if (ndone == 0) check("run_timeout", 32'd0, 32'd1);
        check("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        int nres, ndone;
        rst = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        start = 1'b0; start3 = 1'b0; num_vec = '0;
        #2;
        check("rst_abc",   32'({a, b, cin}), 32'd0);
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_data",  32'(res_data), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            load(3'(i), 3'(i));
            mem_m[i] = 3'(i);
        end

        // Full run over all eight vectors
        run_collect(4'd8, nres, ndone);
        check("r8_count", 32'(nres), 32'd8);
        check("r8_done",  32'(ndone), 32'd1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("r8_data%0d", i), 32'(res_d[i]), 32'(exp22[i]));
            check($sformatf("r8_idx%0d", i),  32'(res_i[i]), 32'(i));
            check($sformatf("r8_time%0d", i), 32'(res_t[i]), 32'(4 + 4 * i));
        end
        check("r8_hold_abc", 32'({a, b, cin}), 32'd7);
        check("r8_busy_low", 32'(busy), 32'd0);

        // Empty run
        num_vec = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check("r0_busy_c1",  32'(busy), 32'd1);
        check("r0_done_c1",  32'(done), 32'd0);
        check("r0_valid_c1", 32'(res_valid), 32'd0);
        tick();
        check("r0_done_c2",  32'(done), 32'd1);
        check("r0_busy_c2",  32'(busy), 32'd0);
        check("r0_valid_c2", 32'(res_valid), 32'd0);
        tick();
        check("r0_done_c3",  32'(done), 32'd0);

        // Oversized count clamps to DEPTH
        run_collect(4'd12, nres, ndone);
        check("r12_count",   32'(nres), 32'd8);
        check("r12_lastidx", 32'(res_i[7]), 32'd7);
        check("r12_done",    32'(ndone), 32'd1);

        // Write during busy is dropped
        num_vec = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        load(3'd0, 3'd7);
        for (int n = 0; n < 50 && busy; n++) tick();
        check("wbusy_idle", 32'(busy), 32'd0);
        tick();
        run_collect(4'd1, nres, ndone);
        check("wbusy_count", 32'(nres), 32'd1);
        check("wbusy_data",  32'(res_d[0]), 32'(exp22[0]));

        // Write and start in the same idle cycle
        ld_en = 1'b1; ld_addr = 3'd0; ld_data = 3'b110;
        mem_m[0] = 3'b110;
        num_vec = 4'd1; start = 1'b1;
        tick();
        ld_en = 1'b0; start = 1'b0;
        for (int n = 0; n < 50 && !res_valid; n++) tick();
        check("wstart_data", 32'(res_data), 32'b10);
        for (int n = 0; n < 50 && busy; n++) tick();
        tick();

        // Reset in the WAIT of vector 3, then replay
        num_vec = 4'd8; start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 13; n++) tick();
        rst = 1'b1;
        #1;
        check("arst_abc",   32'({a, b, cin}), 32'd0);
        check("arst_valid", 32'(res_valid), 32'd0);
        check("arst_idx",   32'(res_idx), 32'd0);
        check("arst_data",  32'(res_data), 32'd0);
        check("arst_busy",  32'(busy), 32'd0);
        tick();
        check("arst_nodone", 32'(done), 32'd0);
        rst = 1'b0;
        tick();
        check("arst_nodone2", 32'(done), 32'd0);
        run_collect(4'd8, nres, ndone);
        check("replay_count", 32'(nres), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("replay_data%0d", i), 32'(res_d[i]), 32'(fa(mem_m[i])));
            check($sformatf("replay_idx%0d", i),  32'(res_i[i]), 32'(i));
        end

        // SETTLE=3 instance: hold time and latency
        num_vec = 4'd2; start3 = 1'b1;
        tick();
        start3 = 1'b0;
        check("s3_busy", 32'(busy3), 32'd1);
        for (int n = 1; n <= 5; n++) begin
            tick();
            if (n <= 4) begin
                check($sformatf("s3_abc_n%0d", n), 32'({a3, b3, cin3}), 32'(mem_m[0]));
                check($sformatf("s3_novalid_n%0d", n), 32'(res_valid3), 32'd0);
            end else begin
                check("s3_valid_n5", 32'(res_valid3), 32'd1);
                check("s3_data",     32'(res_data3), 32'(fa(mem_m[0])));
                check("s3_idx",      32'(res_idx3), 32'd0);
            end
        end
        begin
            int seen = 0;
            for (int n = 0; n < 60 && seen == 0; n++) begin
                if (done3) seen = 1;
                tick();
            end
            check("s3_done", 32'(seen), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/adder_vec_seq.md
ADDER_VEC_SEQ -- requirements
Module: adder_vec_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1: operand width of the downstream adder.
REQ-002 The block SHALL have parameter DEPTH, default 8: vector memory entries (power of two, 2..256).
REQ-003 The block SHALL have parameter SETTLE, default 2: cycles operands are held before the response is sampled (1..15).
REQ-004 The block SHALL have these ports (one clock; reset is asynchronous and active-high):
  clk       in   1                 sole clock, rising edge
  rst       in   1                 asynchronous, active-high reset
  ld_en     in   1                 write one vector into memory
  ld_addr   in   log2(DEPTH)       write address
  ld_data   in   2*WIDTH+1         vector {a,b,cin}
  start     in   1                 one-cycle pulse, begin a run
  num_vec   in   log2(DEPTH)+1     vectors to play (0 = none)
  a         out  WIDTH             operand to adder
  b         out  WIDTH             operand to adder
  cin       out  1                 carry-in to adder
  x         in   WIDTH             adder sum/difference result
  y         in   1                 adder carry/borrow result
  res_valid out  1                 one-cycle strobe, response captured
  res_idx   out  log2(DEPTH)       vector index of captured response
  res_data  out  WIDTH+1           captured {y,x}
  busy      out  1                 run in progress
  done      out  1                 one-cycle pulse, run complete

Function
REQ-005 The block SHALL implement FSM states IDLE, DRIVE, WAIT, CAPTURE, FINISH.
REQ-006 IDLE -> DRIVE on start with num_vec != 0; IDLE -> FINISH on start with num_vec == 0; start is ignored outside IDLE.
REQ-007 Run length SHALL be min(num_vec, DEPTH), latched at start.
REQ-008 DRIVE SHALL register {a,b,cin} = mem[idx] with idx starting at 0, then go to WAIT.
REQ-009 WAIT SHALL last exactly SETTLE cycles with a/b/cin held stable, then go to CAPTURE.
REQ-010 CAPTURE SHALL register res_data = {y,x} and res_idx = idx, assert res_valid for exactly one cycle, and increment idx.
REQ-011 After CAPTURE, the FSM SHALL go to DRIVE if more vectors remain, else to FINISH.
REQ-012 FINISH SHALL assert done for one cycle and return to IDLE; a, b, cin SHALL hold the last driven vector.
REQ-013 Per-vector latency from DRIVE entry to the res_valid strobe SHALL be SETTLE+2 cycles, with no gap between vectors.
REQ-014 busy SHALL be high in DRIVE, WAIT, CAPTURE and FINISH, and low in IDLE.
REQ-015 ld_en SHALL be accepted only in IDLE; writes during busy are dropped.
REQ-016 A write and a start in the same IDLE cycle SHALL both take effect, with the run reading the new data.
REQ-017 idx SHALL never wrap within a run; a run of DEPTH vectors ends after index DEPTH-1.

Reset
REQ-018 rst SHALL force the FSM to IDLE and clear idx, a, b, cin, res_data, res_idx, res_valid, busy and done to 0, asynchronously.
REQ-019 Reset mid-run SHALL abort the run without a done pulse; memory contents SHALL be preserved (no reset on the array).

Structure
REQ-020 FSM state encoding and the vector-width helper constant SHALL live in the shared package adder_pkg.
REQ-021 The vector memory SHALL be a sub-module vec_mem (synchronous write, combinational read).

Verification
REQ-022 Load the 8 vectors 000..111, start with num_vec=8, WIDTH=1 full adder -> 8 res_valid strobes, res_data = 00,01,01,10,01,10,10,11, then one done.
REQ-023 start with num_vec=0 -> done two cycles later, no res_valid, busy high for one cycle.
REQ-024 num_vec=12 with DEPTH=8 -> exactly 8 responses, last res_idx=7.
REQ-025 SETTLE=3: check that a/b/cin are stable for 3 cycles and res_valid occurs 5 cycles after DRIVE entry.
REQ-026 Assert rst during the WAIT of vector 3 -> all outputs 0 immediately, no done; a restart replays from index 0 using unchanged memory.
REQ-027 ld_en during busy writing 111 at address 0 -> the next run still plays the original mem[0].
